// File: rtl/mig_tt_sweeper_if.sv
// Sweeper <-> harness bundle: control/result signals plus the pi/po pins to the netlist.
interface mig_tt_sweeper_if #(
   parameter int N_PI = 4,
   parameter int N_PO = 1
);
   localparam int TTW = N_PO * (1 << N_PI);

   logic            start;
   logic            abort;
   logic [TTW-1:0]  expected_tt;
   logic [N_PI-1:0] pi;
   logic [N_PO-1:0] po;
   logic            busy;
   logic            done;
   logic            pass;
   logic [TTW-1:0]  tt_out;
   logic [N_PI:0]   mismatch_cnt;
   logic [N_PI-1:0] first_fail;

   modport master (
      output start, abort, expected_tt, po,
      input  pi, busy, done, pass, tt_out, mismatch_cnt, first_fail
   );

   modport slave (
      input  start, abort, expected_tt, po,
      output pi, busy, done, pass, tt_out, mismatch_cnt, first_fail
   );
endinterface

// File: rtl/mig_tt_sweeper.sv
// Exhaustive pi sweep of a MIG netlist, po capture into a truth table and compare against a golden copy.
// Each pattern takes SETTLE+1 cycles; start is ignored while busy, abort cancels a sweep.
module mig_tt_sweeper #(
   parameter int N_PI   = 4,
   parameter int N_PO   = 1,
   parameter int SETTLE = 0
) (
   input logic          clk,
   input logic          rst_n,
   mig_tt_sweeper_if.slave bus
);
   localparam int NPAT = 1 << N_PI;
   localparam int TTW  = N_PO * NPAT;
   localparam int CW   = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state;
   logic [N_PI-1:0] idx;
   logic [CW-1:0]   cnt;
   logic [TTW-1:0]  exp_q;
   logic [TTW-1:0]  tt_q;
   logic [N_PI:0]   miss_q;
   logic [N_PI-1:0] first_q;
   logic            busy_q;
   logic            done_q;
   logic            pass_q;

   logic [N_PO-1:0] exp_slice;
   logic            differ;

   assign exp_slice = exp_q[int'(idx) * N_PO +: N_PO];
   assign differ    = (bus.po != exp_slice);

   assign bus.pi           = idx;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.pass         = pass_q;
   assign bus.tt_out       = tt_q;
   assign bus.mismatch_cnt = miss_q;
   assign bus.first_fail   = first_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         idx     <= '0;
         cnt     <= '0;
         exp_q   <= '0;
         tt_q    <= '0;
         miss_q  <= '0;
         first_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  state   <= RUN;
                  exp_q   <= bus.expected_tt;
                  tt_q    <= '0;
                  miss_q  <= '0;
                  first_q <= '0;
                  pass_q  <= 1'b0;
                  idx     <= '0;
                  cnt     <= CW'(SETTLE);
                  busy_q  <= 1'b1;
               end
            end
            RUN: begin
               // abort outranks a sample landing on the same edge
               if (bus.abort) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  pass_q <= 1'b0;
                  idx    <= '0;
               end else if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else begin
                  tt_q[int'(idx) * N_PO +: N_PO] <= bus.po;
                  if (differ) begin
                     miss_q <= miss_q + (N_PI + 1)'(1);
                     if (miss_q == '0)
                        first_q <= idx;
                  end
                  if (&idx) begin
                     state  <= DONE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                     pass_q <= (miss_q == '0) && !differ;
                  end else begin
                     idx <= idx + N_PI'(1);
                     cnt <= CW'(SETTLE);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mig_tt_sweeper.sv
// Directed bench: combinational netlist on a SETTLE=0 sweeper, registered majority on a SETTLE=2 sweeper.
module tb_mig_tt_sweeper;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   mig_tt_sweeper_if #(.N_PI(4), .N_PO(1)) if0 ();
   mig_tt_sweeper_if #(.N_PI(4), .N_PO(1)) if2 ();

   mig_tt_sweeper #(.N_PI(4), .N_PO(1), .SETTLE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(if0.slave)
   );
   mig_tt_sweeper #(.N_PI(4), .N_PO(1), .SETTLE(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .bus(if2.slave)
   );

   // Netlists under test
   logic maj_q = 1'b0;
   assign if0.po[0] = if0.pi[2] & if0.pi[3] & (if0.pi[0] | if0.pi[1]);
   always_ff @(posedge clk)
      maj_q <= (if2.pi[0] & if2.pi[1]) | (if2.pi[0] & if2.pi[2]) | (if2.pi[1] & if2.pi[2]);
   assign if2.po[0] = maj_q;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic start0(input logic [15:0] exp_tt);
      if0.start = 1'b1;
      if0.expected_tt = exp_tt;
      @(negedge clk);
      if0.start = 1'b0;
   endtask

   task automatic results0(input string tag, input logic [15:0] tt, input logic ps,
                           input logic [4:0] mc, input logic [3:0] ff);
      check({tag, "_tt"}, 32'(if0.tt_out), 32'(tt));
      check({tag, "_pass"}, 32'(if0.pass), 32'(ps));
      check({tag, "_mcnt"}, 32'(if0.mismatch_cnt), 32'(mc));
      check({tag, "_ffail"}, 32'(if0.first_fail), 32'(ff));
   endtask

   initial begin
      if0.start = 1'b0; if0.abort = 1'b0; if0.expected_tt = '0;
      if2.start = 1'b0; if2.abort = 1'b0; if2.expected_tt = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(if0.busy), 0);
      check("rst_pi", 32'(if0.pi), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_done", 32'(if0.done), 0);
      results0("idle", 16'h0000, 1'b0, 5'd0, 4'd0);

      // Matching sweep, one pattern per cycle
      start0(16'hE000);
      for (int i = 0; i < 16; i++) begin
         check("t1_pi", 32'(if0.pi), 32'(i));
         check("t1_busy", 32'(if0.busy), 1);
         check("t1_done", 32'(if0.done), 0);
         @(negedge clk);
      end
      check("t1_done_hi", 32'(if0.done), 1);
      check("t1_busy_lo", 32'(if0.busy), 0);
      check("t1_pi_last", 32'(if0.pi), 15);
      results0("t1", 16'hE000, 1'b1, 5'd0, 4'd0);
      @(negedge clk);
      check("t1_done_pulse", 32'(if0.done), 0);
      results0("t1_hold", 16'hE000, 1'b1, 5'd0, 4'd0);

      // Single mismatch at pattern 0; a mid-run golden change must not matter
      start0(16'hE001);
      repeat (5) @(negedge clk);
      if0.expected_tt = 16'h0000;
      repeat (11) @(negedge clk);
      check("t2_done", 32'(if0.done), 1);
      results0("t2", 16'hE000, 1'b0, 5'd1, 4'd0);

      // SETTLE=2 against a registered majority
      if2.start = 1'b1;
      if2.expected_tt = 16'hE8E8;
      @(negedge clk);
      if2.start = 1'b0;
      for (int i = 0; i < 48; i++) begin
         check("t3_pi", 32'(if2.pi), 32'(i / 3));
         check("t3_busy", 32'(if2.busy), 1);
         @(negedge clk);
      end
      check("t3_done", 32'(if2.done), 1);
      check("t3_busy_lo", 32'(if2.busy), 0);
      check("t3_tt", 32'(if2.tt_out), 32'h0000E8E8);
      check("t3_pass", 32'(if2.pass), 1);
      check("t3_mcnt", 32'(if2.mismatch_cnt), 0);

      // start re-pulsed mid-sweep is ignored
      start0(16'hE000);
      for (int i = 0; i < 16; i++) begin
         check("t4_pi", 32'(if0.pi), 32'(i));
         check("t4_done", 32'(if0.done), 0);
         if0.start = (i == 5);
         @(negedge clk);
      end
      if0.start = 1'b0;
      check("t4_done_hi", 32'(if0.done), 1);
      results0("t4", 16'hE000, 1'b1, 5'd0, 4'd0);

      // abort at pattern 9: patterns 0..8 sampled, all mismatch against all-ones
      start0(16'hFFFF);
      repeat (9) @(negedge clk);
      check("t4a_pi", 32'(if0.pi), 9);
      if0.abort = 1'b1;
      @(negedge clk);
      if0.abort = 1'b0;
      check("t4a_busy", 32'(if0.busy), 0);
      check("t4a_done", 32'(if0.done), 0);
      check("t4a_pi0", 32'(if0.pi), 0);
      results0("t4a", 16'h0000, 1'b0, 5'd9, 4'd0);
      @(negedge clk);
      check("t4a_nodone", 32'(if0.done), 0);
      check("t4a_idle", 32'(if0.busy), 0);

      // async reset mid-sweep
      start0(16'hE000);
      repeat (7) @(negedge clk);
      check("t5_pi", 32'(if0.pi), 7);
      rst_n = 1'b0;
      #1;
      check("t5_busy", 32'(if0.busy), 0);
      check("t5_pi0", 32'(if0.pi), 0);
      check("t5_done", 32'(if0.done), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("t5_idle_busy", 32'(if0.busy), 0);
      check("t5_idle_done", 32'(if0.done), 0);
      start0(16'hE000);
      repeat (16) @(negedge clk);
      check("t5_done_hi", 32'(if0.done), 1);
      results0("t5", 16'hE000, 1'b1, 5'd0, 4'd0);

      // back-to-back start in the done cycle, with start and abort both high
      if0.start = 1'b1;
      if0.abort = 1'b1;
      if0.expected_tt = 16'h0000;
      @(negedge clk);
      if0.start = 1'b0;
      if0.abort = 1'b0;
      check("t6_busy", 32'(if0.busy), 1);
      check("t6_pi", 32'(if0.pi), 0);
      results0("t6_clr", 16'h0000, 1'b0, 5'd0, 4'd0);
      repeat (16) @(negedge clk);
      check("t6_done", 32'(if0.done), 1);
      results0("t6", 16'hE000, 1'b0, 5'd3, 4'd13);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
